// File: rtl/ifc_and_unit_if.sv
// rtl/ifc_and_unit_if.sv - method-style handshake bundle for the AND unit
interface ifc_and_unit_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a_data;
  logic             a_en;
  logic             a_rdy;
  logic [WIDTH-1:0] b_data;
  logic             b_en;
  logic             b_rdy;
  logic             y_en;
  logic [WIDTH-1:0] y_data;
  logic             y_rdy;

  modport master (
    output a_data, a_en, b_data, b_en, y_en,
    input  a_rdy, b_rdy, y_data, y_rdy
  );

  modport slave (
    input  a_data, a_en, b_data, b_en, y_en,
    output a_rdy, b_rdy, y_data, y_rdy
  );
endinterface

// File: rtl/ifc_and_unit.sv
// rtl/ifc_and_unit.sv - two operand FIFOs whose heads are ANDed and popped together
module ifc_and_unit #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input logic           CLK,
  input logic           RST_N,  // active-high synchronous reset despite the name
  ifc_and_unit_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];

  logic [PW-1:0] rd_a, wr_a, rd_b, wr_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [CW-1:0] cnt_a_nxt, cnt_b_nxt;

  logic a_fire, b_fire, y_fire;

  // Guards depend only on registered state and reset, never on the enables
  assign bus.a_rdy  = (cnt_a != CNT_FULL) & ~RST_N;
  assign bus.b_rdy  = (cnt_b != CNT_FULL) & ~RST_N;
  assign bus.y_rdy  = (cnt_a != '0) & (cnt_b != '0) & ~RST_N;
  assign bus.y_data = bus.y_rdy ? (mem_a[rd_a] & mem_b[rd_b]) : '0;

  assign a_fire = bus.a_en & bus.a_rdy;
  assign b_fire = bus.b_en & bus.b_rdy;
  assign y_fire = bus.y_en & bus.y_rdy;

  always_comb begin
    cnt_a_nxt = cnt_a;
    unique case ({a_fire, y_fire})
      2'b10:   cnt_a_nxt = cnt_a + CNT_ONE;
      2'b01:   cnt_a_nxt = cnt_a - CNT_ONE;
      default: cnt_a_nxt = cnt_a;
    endcase
  end

  always_comb begin
    cnt_b_nxt = cnt_b;
    unique case ({b_fire, y_fire})
      2'b10:   cnt_b_nxt = cnt_b + CNT_ONE;
      2'b01:   cnt_b_nxt = cnt_b - CNT_ONE;
      default: cnt_b_nxt = cnt_b;
    endcase
  end

  // Storage has no reset; the fire terms are already gated off during reset
  always_ff @(posedge CLK) begin
    if (a_fire) mem_a[wr_a] <= bus.a_data;
    if (b_fire) mem_b[wr_b] <= bus.b_data;
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      rd_a  <= '0;
      wr_a  <= '0;
      rd_b  <= '0;
      wr_b  <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_fire) wr_a <= wr_a + PTR_ONE;
      if (b_fire) wr_b <= wr_b + PTR_ONE;
      if (y_fire) begin
        rd_a <= rd_a + PTR_ONE;
        rd_b <= rd_b + PTR_ONE;
      end
      cnt_a <= cnt_a_nxt;
      cnt_b <= cnt_b_nxt;
    end
  end

endmodule

// File: tb/tb_ifc_and_unit.sv
// tb/tb_ifc_and_unit.sv - directed and random checks of ifc_and_unit against a queue model
module tb_ifc_and_unit;

  localparam int WIDTH = 1;
  localparam int DEPTH = 2;

  logic CLK;
  logic RST_N;

  ifc_and_unit_if #(.WIDTH(WIDTH)) bus ();

  ifc_and_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic             rst;
    logic             e_ardy, e_brdy, e_yrdy;
    logic [WIDTH-1:0] e_y;
    rst    = RST_N;
    e_ardy = !rst && (qa.size() < DEPTH);
    e_brdy = !rst && (qb.size() < DEPTH);
    e_yrdy = !rst && (qa.size() > 0) && (qb.size() > 0);
    e_y    = e_yrdy ? (qa[0] & qb[0]) : '0;
    check({tag, ".a_rdy"},  32'(bus.a_rdy),  32'(e_ardy));
    check({tag, ".b_rdy"},  32'(bus.b_rdy),  32'(e_brdy));
    check({tag, ".y_rdy"},  32'(bus.y_rdy),  32'(e_yrdy));
    check({tag, ".y_data"}, 32'(bus.y_data), 32'(e_y));
  endtask

  // One clock of stimulus: drive, check pre-edge outputs, advance the model at the edge
  task automatic drive(input string tag, input logic rst,
                       input logic ae, input logic [WIDTH-1:0] ad,
                       input logic be, input logic [WIDTH-1:0] bd,
                       input logic ye);
    bit a_ok, b_ok, y_ok;
    RST_N      = rst;
    bus.a_en   = ae;
    bus.a_data = ad;
    bus.b_en   = be;
    bus.b_data = bd;
    bus.y_en   = ye;
    #1;
    check_outputs(tag);
    a_ok = !rst && ae && (qa.size() < DEPTH);
    b_ok = !rst && be && (qb.size() < DEPTH);
    y_ok = !rst && ye && (qa.size() > 0) && (qb.size() > 0);
    @(posedge CLK);
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (y_ok) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (a_ok) qa.push_back(ad);
      if (b_ok) qb.push_back(bd);
    end
    #1;
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    RST_N      = 1'b1;
    bus.a_en   = 1'b0;
    bus.a_data = '0;
    bus.b_en   = 1'b0;
    bus.b_data = '0;
    bus.y_en   = 1'b0;

    // Reset held two cycles, enables asserted to show they are blocked
    drive("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive("rst1", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check("rst.y_rdy_hold", 32'(bus.y_rdy), 32'd0);
    idle("release");
    check("release.a_rdy", 32'(bus.a_rdy), 32'd1);
    check("release.b_rdy", 32'(bus.b_rdy), 32'd1);
    check("release.y_rdy", 32'(bus.y_rdy), 32'd0);

    // Truth table
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      drive("tt_enq", 1'b0, 1'b1, WIDTH'(ab[1]), 1'b1, WIDTH'(ab[0]), 1'b0);
      check("tt.y_rdy", 32'(bus.y_rdy), 32'd1);
      check("tt.y_data", 32'(bus.y_data), 32'(ab[1] & ab[0]));
      drive("tt_deq", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      check("tt.y_rdy_drop", 32'(bus.y_rdy), 32'd0);
    end

    // Ordering with imbalance, and an ignored enqueue into a full FIFO
    drive("ord_a0", 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive("ord_a1", 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("ord.a_full", 32'(bus.a_rdy), 32'd0);
    check("ord.y_wait", 32'(bus.y_rdy), 32'd0);
    drive("full_ign", 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    drive("ord_b0", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    drive("ord_b1", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("ord.first", 32'(bus.y_data), 32'd1);
    drive("ord_y0", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("ord.second", 32'(bus.y_data), 32'd0);
    drive("ord_y1", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("ord.empty", 32'(bus.y_rdy), 32'd0);

    // Concurrent enqueue and dequeue at count 1
    drive("cc_fill", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("cc_all", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("cc.y_data", 32'(bus.y_data), 32'd1);
    check("cc.a_rdy_cnt1", 32'(bus.a_rdy), 32'd1);
    drive("cc_drain", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("cc.cnt_was_1", 32'(bus.y_rdy), 32'd0);

    // Reset in the middle of traffic discards queued operands
    drive("mr_f0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("mr_f1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("mr_rst", 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    idle("mr_rel");
    check("mr.y_rdy", 32'(bus.y_rdy), 32'd0);
    check("mr.a_rdy", 32'(bus.a_rdy), 32'd1);
    check("mr.b_rdy", 32'(bus.b_rdy), 32'd1);
    drive("mr_b", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("mr.no_old", 32'(bus.y_rdy), 32'd0);

    // Random traffic against the queue model, with rare resets
    for (int i = 0; i < 400; i++) begin
      drive("rnd",
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0), WIDTH'($urandom),
            ($urandom_range(0, 2) != 0), WIDTH'($urandom),
            ($urandom_range(0, 2) != 0));
    end
    idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
